// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared select-code constants for the decoder scan driver
package scan_pkg;
    localparam int SEL_W = 2;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [SEL_W-1:0] SEL_MIN = 2'd0;
    localparam logic [SEL_W-1:0] SEL_MAX = 2'd3;

    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - enable-gated divide-by-DIV counter producing the scan tick
module scan_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // With DIV=1 the counter is pinned at 0 == LAST, so every enabled cycle ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign tick = en && (cnt == LAST);
endmodule

// File: rtl/decoder_scan_driver.sv
// rtl/decoder_scan_driver.sv - 2-bit decoder select scanner; SCAN_SKIP_EN adds skip_mask
module decoder_scan_driver
    import scan_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             ld,
    input  logic [SEL_W-1:0] ld_code,
`ifdef SCAN_SKIP_EN
    input  logic [3:0]       skip_mask,
`endif
    output logic [SEL_W-1:0] sel,
    output logic             step,
    output logic             frame
);
    logic tick;
    sel_t next_sel;
    logic next_wrap;

    scan_prescaler #(.DIV(DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (ld),
        .tick (tick)
    );

`ifdef SCAN_SKIP_EN
    sel_t cand;
    logic found;

    // Walk up to a full circle; landing back on sel itself still counts as a wrap.
    always_comb begin
        next_sel  = sel;
        next_wrap = 1'b0;
        cand      = sel;
        found     = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = (dir == DIR_DOWN) ? sel - k[SEL_W-1:0] : sel + k[SEL_W-1:0];
            if (!found && !skip_mask[cand]) begin
                found     = 1'b1;
                next_sel  = cand;
                next_wrap = (dir == DIR_DOWN) ? (int'(sel) - k < int'(SEL_MIN))
                                              : (int'(sel) + k > int'(SEL_MAX));
            end
        end
    end
`else
    always_comb begin
        next_sel  = (dir == DIR_UP) ? sel + sel_t'(1) : sel - sel_t'(1);
        next_wrap = (dir == DIR_UP) ? (sel == SEL_MAX) : (sel == SEL_MIN);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel   <= SEL_MIN;
            step  <= 1'b0;
            frame <= 1'b0;
        end else if (ld) begin
            sel   <= ld_code;
            step  <= 1'b0;
            frame <= 1'b0;
        end else if (tick) begin
            sel   <= next_sel;
            step  <= 1'b1;
            frame <= next_wrap;
        end else begin
            step  <= 1'b0;
            frame <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decoder_scan_driver.sv
// tb/tb_decoder_scan_driver.sv - vector-table bench for decoder_scan_driver (DIV=4)
module tb_decoder_scan_driver;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       ld = 1'b0;
    logic [1:0] ld_code = 2'd0;
    logic [3:0] skip_mask = 4'd0;
    logic [1:0] sel;
    logic       step;
    logic       frame;

    decoder_scan_driver #(.DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dir       (dir),
        .ld        (ld),
        .ld_code   (ld_code),
`ifdef SCAN_SKIP_EN
        .skip_mask (skip_mask),
`endif
        .sel       (sel),
        .step      (step),
        .frame     (frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       dir;
        logic       ld;
        logic [1:0] code;
        logic [3:0] mask;
        logic [1:0] sel;
        logic       step;
        logic       frame;
    } vec_t;

    vec_t       vq[$];
    logic [3:0] cur_mask = 4'd0;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_v(input logic e, input logic d, input logic l, input logic [1:0] c,
                         input logic [1:0] s, input logic st, input logic fr);
        vec_t v;
        v.en = e; v.dir = d; v.ld = l; v.code = c; v.mask = cur_mask;
        v.sel = s; v.step = st; v.frame = fr;
        vq.push_back(v);
    endtask

    // One full scan step: DIV-1 idle enabled cycles then the tick edge.
    task automatic add_step(input logic d, input logic [1:0] prev, input logic [1:0] nxt,
                            input logic fr);
        for (int i = 0; i < DIV - 1; i++) add_v(1'b1, d, 1'b0, 2'd0, prev, 1'b0, 1'b0);
        add_v(1'b1, d, 1'b0, 2'd0, nxt, 1'b1, fr);
    endtask

    initial begin
        #1;
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_step", 32'(step), 32'd0);
        chk("reset_frame", 32'(frame), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        add_step(1'b0, 2'd0, 2'd1, 1'b0);
        add_step(1'b0, 2'd1, 2'd2, 1'b0);
        add_step(1'b0, 2'd2, 2'd3, 1'b0);
        add_step(1'b0, 2'd3, 2'd0, 1'b1);
        add_step(1'b1, 2'd0, 2'd3, 1'b1);
        add_step(1'b1, 2'd3, 2'd2, 1'b0);
        add_step(1'b1, 2'd2, 2'd1, 1'b0);
        add_step(1'b1, 2'd1, 2'd0, 1'b0);
        add_step(1'b1, 2'd0, 2'd3, 1'b1);
        // ld coincident with a tick wins and restarts the prescaler
        for (int i = 0; i < DIV - 1; i++) add_v(1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0);
        add_v(1'b1, 1'b0, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0);
        add_step(1'b0, 2'd2, 2'd3, 1'b0);
        // freeze at prescaler=2 for 10 cycles, dir wiggling meanwhile
        add_v(1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0);
        add_v(1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) add_v(1'b0, i[0], 1'b0, 2'd0, 2'd3, 1'b0, 1'b0);
        add_v(1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0);
        add_v(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
        // ld honoured with en=0
        add_v(1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0);
        add_step(1'b0, 2'd1, 2'd2, 1'b0);
`ifdef SCAN_SKIP_EN
        add_v(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
        cur_mask = 4'b0100;
        add_step(1'b0, 2'd0, 2'd1, 1'b0);
        add_step(1'b0, 2'd1, 2'd3, 1'b0);
        add_step(1'b0, 2'd3, 2'd0, 1'b1);
        cur_mask = 4'b1111;
        add_step(1'b0, 2'd0, 2'd0, 1'b0);
        add_v(1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0);
        add_step(1'b1, 2'd2, 2'd2, 1'b0);
        cur_mask = 4'b0000;
`endif

        foreach (vq[i]) begin
            @(negedge clk);
            en = vq[i].en; dir = vq[i].dir; ld = vq[i].ld; ld_code = vq[i].code;
            skip_mask = vq[i].mask;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_sel", i), 32'(sel), 32'(vq[i].sel));
            chk($sformatf("v%0d_step", i), 32'(step), 32'(vq[i].step));
            chk($sformatf("v%0d_frame", i), 32'(frame), 32'(vq[i].frame));
        end

        // async reset mid-count with sel=3, ld/en ignored while held
        @(negedge clk);
        en = 1'b0; ld = 1'b1; ld_code = 2'd3;
        @(posedge clk);
        #1 chk("pre_rst_sel", 32'(sel), 32'd3);
        @(negedge clk);
        ld = 1'b0; en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sel", 32'(sel), 32'd0);
        chk("async_rst_step", 32'(step), 32'd0);
        chk("async_rst_frame", 32'(frame), 32'd0);
        @(negedge clk);
        ld = 1'b1; ld_code = 2'd2;
        @(posedge clk);
        #1 chk("rst_ignores_ld", 32'(sel), 32'd0);
        @(negedge clk);
        ld = 1'b0; rst = 1'b0;
        for (int k = 1; k <= DIV; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_e%0d_step", k), 32'(step), (k == DIV) ? 32'd1 : 32'd0);
            chk($sformatf("post_rst_e%0d_sel", k), 32'(sel), (k == DIV) ? 32'd1 : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
